// File: rtl/clk_div_multi.sv
`default_nettype none
// =============================================================================
// Module      : clk_div_multi
// Description : Multi-channel programmable tick / pulse / square / PWM
//               generator. Per-channel config is double-buffered so it is
//               applied only at a period boundary, a sync, or while disabled.
// Revision    : 1.0 - initial release
// =============================================================================
module clk_div_multi #(
  parameter int CHANNELS = 4,
  parameter int WIDTH    = 16,
  parameter int CH_W     = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                cfg_we,
  input  logic [CH_W-1:0]     cfg_ch,
  input  logic [WIDTH-1:0]    cfg_div,
  input  logic [WIDTH-1:0]    cfg_duty,
  input  logic [1:0]          cfg_mode,
  input  logic                cfg_en,
  input  logic                sync,
  output logic [CHANNELS-1:0] tick,
  output logic [CHANNELS-1:0] out,
  output logic [CHANNELS-1:0] pending
);

  localparam logic [1:0] MODE_PULSE  = 2'd0;
  localparam logic [1:0] MODE_SQUARE = 2'd1;
  localparam logic [1:0] MODE_PWM    = 2'd2;

  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    // active configuration
    logic [WIDTH-1:0] div_a;
    logic [WIDTH-1:0] duty_a;
    logic [1:0]       mode_a;
    logic             en_a;
    // shadow configuration
    logic [WIDTH-1:0] div_s;
    logic [WIDTH-1:0] duty_s;
    logic [1:0]       mode_s;
    logic             en_s;
    // run state
    logic [WIDTH-1:0] cnt;
    logic             pend;
    logic             sq;
    logic             tick_r;
    logic             out_r;

    logic             hit;
    logic             term;
    logic             eff_pend;
    logic             apply;
    logic [WIDTH-1:0] div_n;
    logic [WIDTH-1:0] duty_n;
    logic [1:0]       mode_n;
    logic             en_n;
    logic [WIDTH-1:0] cnt_n;
    logic             pend_n;
    logic             sq_n;
    logic             tick_n;
    logic             out_n;

    always_comb begin
      hit      = cfg_we && (cfg_ch == CH_W'(i));
      term     = en_a && (cnt == div_a);
      // a write landing in an apply cycle is treated as already pending
      eff_pend = pend || hit;
      apply    = eff_pend && (!en_a || term || sync);

      div_n  = div_a;
      duty_n = duty_a;
      mode_n = mode_a;
      en_n   = en_a;
      pend_n = eff_pend;
      if (apply) begin
        div_n  = hit ? cfg_div  : div_s;
        duty_n = hit ? cfg_duty : duty_s;
        mode_n = hit ? cfg_mode : mode_s;
        en_n   = hit ? cfg_en   : en_s;
        pend_n = 1'b0;
      end

      // terminal tick of the old period still fires; sync suppresses it
      tick_n = term && !sync;

      if (!en_a || sync || apply || term) begin
        cnt_n = '0;
      end else begin
        cnt_n = cnt + WIDTH'(1);
      end

      if (!en_a || sync) begin
        sq_n = 1'b0;
      end else if (term) begin
        sq_n = ~sq;
      end else begin
        sq_n = sq;
      end

      if (!en_n) begin
        cnt_n = '0;
        sq_n  = 1'b0;
      end

      out_n = 1'b0;
      if (en_n) begin
        case (mode_n)
          MODE_PULSE:  out_n = tick_n;
          MODE_SQUARE: out_n = sq_n;
          MODE_PWM:    out_n = (cnt_n < duty_n);
          default:     out_n = 1'b0;
        endcase
      end
    end

    always_ff @(posedge clk) begin
      if (rst) begin
        div_a  <= '0;
        duty_a <= '0;
        mode_a <= '0;
        en_a   <= 1'b0;
        div_s  <= '0;
        duty_s <= '0;
        mode_s <= '0;
        en_s   <= 1'b0;
        cnt    <= '0;
        pend   <= 1'b0;
        sq     <= 1'b0;
        tick_r <= 1'b0;
        out_r  <= 1'b0;
      end else begin
        if (hit) begin
          div_s  <= cfg_div;
          duty_s <= cfg_duty;
          mode_s <= cfg_mode;
          en_s   <= cfg_en;
        end
        div_a  <= div_n;
        duty_a <= duty_n;
        mode_a <= mode_n;
        en_a   <= en_n;
        cnt    <= cnt_n;
        pend   <= pend_n;
        sq     <= sq_n;
        tick_r <= tick_n;
        out_r  <= out_n;
      end
    end

    assign tick[i]    = tick_r;
    assign out[i]     = out_r;
    assign pending[i] = pend;
  end

endmodule
`default_nettype wire

// File: tb/tb_clk_div_multi.sv
`default_nettype none
// Directed, self-checking bench for clk_div_multi (5 channels so that an
// out-of-range channel select can be exercised).
module tb_clk_div_multi;

  localparam int CHANNELS = 5;
  localparam int WIDTH    = 16;
  localparam int CH_W     = 3;

  logic                clk;
  logic                rst;
  logic                cfg_we;
  logic [CH_W-1:0]     cfg_ch;
  logic [WIDTH-1:0]    cfg_div;
  logic [WIDTH-1:0]    cfg_duty;
  logic [1:0]          cfg_mode;
  logic                cfg_en;
  logic                sync;
  logic [CHANNELS-1:0] tick;
  logic [CHANNELS-1:0] out;
  logic [CHANNELS-1:0] pending;

  int n_checks = 0;
  int n_errors = 0;

  clk_div_multi #(
    .CHANNELS (CHANNELS),
    .WIDTH    (WIDTH),
    .CH_W     (CH_W)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .cfg_we   (cfg_we),
    .cfg_ch   (cfg_ch),
    .cfg_div  (cfg_div),
    .cfg_duty (cfg_duty),
    .cfg_mode (cfg_mode),
    .cfg_en   (cfg_en),
    .sync     (sync),
    .tick     (tick),
    .out      (out),
    .pending  (pending)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input int ch, input int dv, input int dt, input int md, input bit en);
    cfg_we   = 1'b1;
    cfg_ch   = CH_W'(ch);
    cfg_div  = WIDTH'(dv);
    cfg_duty = WIDTH'(dt);
    cfg_mode = 2'(md);
    cfg_en   = en;
    step();
    cfg_we   = 1'b0;
  endtask

  initial begin
    rst = 1'b1; cfg_we = 1'b0; cfg_ch = '0; cfg_div = '0; cfg_duty = '0;
    cfg_mode = '0; cfg_en = 1'b0; sync = 1'b0;
    step();
    step();
    check("rst_tick", 32'(tick), 0);
    check("rst_out", 32'(out), 0);
    check("rst_pending", 32'(pending), 0);
    rst = 1'b0;

    // ch0 pulse, div=4: one tick every 5 cycles, first 5 cycles after write
    wr(0, 4, 0, 0, 1'b1);
    check("p_tick0_k0", 32'(tick[0]), 0);
    for (int k = 1; k <= 10; k++) begin
      step();
      check("p_tick0", 32'(tick[0]), 32'(k % 5 == 0));
      check("p_out0", 32'(out[0]), 32'(k % 5 == 0));
      check("p_others", 32'(tick[4:1]), 0);
    end

    // ch1 PWM div=3 duty=2: 1,1,0,0
    wr(1, 3, 2, 2, 1'b1);
    check("pwm_k0", 32'(out[1]), 1);
    for (int k = 1; k <= 8; k++) begin
      step();
      check("pwm_pat", 32'(out[1]), 32'((k % 4) < 2));
    end
    // mid-period rewrite duty=5: pending until the terminal edge
    wr(1, 3, 5, 2, 1'b1);
    check("pwm5_pend_a", 32'(pending[1]), 1);
    check("pwm5_old_a", 32'(out[1]), 1);
    step();
    check("pwm5_pend_b", 32'(pending[1]), 1);
    check("pwm5_old_b", 32'(out[1]), 0);
    step();
    check("pwm5_pend_c", 32'(pending[1]), 1);
    check("pwm5_old_c", 32'(out[1]), 0);
    step();
    check("pwm5_pend_d", 32'(pending[1]), 0);
    check("pwm5_new", 32'(out[1]), 1);
    for (int k = 0; k < 8; k++) begin
      step();
      check("pwm5_high", 32'(out[1]), 1);
    end
    // rewrite duty=0: constant low after the terminal edge
    wr(1, 3, 0, 2, 1'b1);
    check("pwm0_pend", 32'(pending[1]), 1);
    step();
    step();
    step();
    check("pwm0_pend_clr", 32'(pending[1]), 0);
    for (int k = 0; k < 8; k++) begin
      check("pwm0_low", 32'(out[1]), 0);
      step();
    end

    // ch2 square div=2: 3 low, 3 high
    wr(2, 2, 0, 1, 1'b1);
    check("sq2_k0", 32'(out[2]), 0);
    for (int k = 1; k <= 11; k++) begin
      step();
      check("sq2_pat", 32'(out[2]), 32'((k / 3) % 2));
    end
    // ch3 square div=0: toggles every cycle, tick constantly high
    wr(3, 0, 0, 1, 1'b1);
    check("sq3_tick_k0", 32'(tick[3]), 0);
    for (int k = 1; k <= 6; k++) begin
      step();
      check("sq3_tick", 32'(tick[3]), 1);
      check("sq3_out", 32'(out[3]), 32'(k % 2));
    end

    // ch1 pulse div=6, then sync realigns ch0 (div4) and ch1 (div6)
    wr(1, 6, 0, 0, 1'b1);
    repeat (5) step();
    check("sync_pre_pend", 32'(pending[1]), 0);
    sync = 1'b1;
    step();
    sync = 1'b0;
    check("sync_tick0", 32'(tick[0]), 0);
    check("sync_tick1", 32'(tick[1]), 0);
    for (int k = 1; k <= 9; k++) begin
      step();
      check("sync_t0", 32'(tick[0]), 32'(k == 5));
      check("sync_t1", 32'(tick[1]), 32'(k == 7));
    end
    // write ch0 exactly on its terminal edge (k=10): bypass, no pending
    wr(0, 2, 0, 0, 1'b1);
    check("byp_pend", 32'(pending[0]), 0);
    check("byp_tick", 32'(tick[0]), 1);
    check("byp_out", 32'(out[0]), 1);
    for (int k = 11; k <= 13; k++) begin
      step();
      check("byp_t0", 32'(tick[0]), 32'(k == 13));
    end

    // out-of-range channel select: no state change
    wr(5, 1, 1, 1, 1'b1);
    check("bad_ch_pend", 32'(pending), 0);
    check("bad_ch_t0a", 32'(tick[0]), 0);
    step();
    check("bad_ch_t0b", 32'(tick[0]), 0);
    step();
    check("bad_ch_t0c", 32'(tick[0]), 1);

    // disable a running channel: held until terminal edge, then silent
    wr(0, 2, 0, 0, 1'b0);
    check("dis_pend_a", 32'(pending[0]), 1);
    step();
    check("dis_pend_b", 32'(pending[0]), 1);
    step();
    check("dis_pend_c", 32'(pending[0]), 0);
    for (int k = 0; k < 6; k++) begin
      step();
      check("dis_tick", 32'(tick[0]), 0);
      check("dis_out", 32'(out[0]), 0);
    end

    // reset mid-operation overrides a simultaneous write and sync
    step();
    rst    = 1'b1;
    cfg_we = 1'b1;
    cfg_ch = 3'd1;
    cfg_en = 1'b1;
    sync   = 1'b1;
    step();
    rst    = 1'b0;
    cfg_we = 1'b0;
    sync   = 1'b0;
    check("mrst_tick", 32'(tick), 0);
    check("mrst_out", 32'(out), 0);
    check("mrst_pend", 32'(pending), 0);
    repeat (4) step();
    check("mrst_tick_hold", 32'(tick), 0);
    check("mrst_out_hold", 32'(out), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
